// File: rtl/ck_rst_gen.sv
// Reset synchroniser/stretcher plus programmable tick and divided enable; rst_n_out rises
// SYNC_STAGES+RST_CYCLES edges after rst_n release, tick is registered (1 cycle after wrap edge), no backpressure.
module ck_rst_gen #(
  parameter int DIV_W       = 16,
  parameter int DIV_DEFAULT = 10,
  parameter int RST_CYCLES  = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TCNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sw_rst,
  input  logic              div_we,
  input  logic [DIV_W-1:0]  div_val,
  input  logic              tick_en,
  output logic              rst_n_out,
  output logic              tick,
  output logic              ck_div,
  output logic [TCNT_W-1:0] tick_count
);

  localparam int HC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HC_W-1:0]  HOLD_LAST   = HC_W'(RST_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_RST_VAL = DIV_W'(DIV_DEFAULT);

  typedef enum logic {
    ST_HOLD,
    ST_RUN
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                w_sync_out;
  logic [HC_W-1:0]     r_hold_cnt;
  logic [HC_W-1:0]     w_hold_cnt_nxt;
  logic                r_rst_n_out;
  logic                w_rst_n_out_nxt;

  logic [DIV_W-1:0]    r_div_reg;
  logic [DIV_W-1:0]    r_cnt;
  logic                r_tick;
  logic                r_ck_div;
  logic [TCNT_W-1:0]   r_tick_count;
  logic [DIV_W-1:0]    w_div_m1;
  logic [DIV_W-1:0]    w_div_wr;
  logic                w_wrap;
  logic                w_div_clr;

  // Release path only: a 1 walks through the chain after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_HOLD;
      r_hold_cnt  <= '0;
      r_rst_n_out <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_rst_n_out <= w_rst_n_out_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_rst_n_out_nxt = r_rst_n_out;
    case (r_state)
      ST_HOLD: begin
        w_rst_n_out_nxt = 1'b0;
        if (sw_rst) begin
          w_hold_cnt_nxt = '0;
        end else if (w_sync_out) begin
          if (r_hold_cnt == HOLD_LAST) begin
            w_state_nxt     = ST_RUN;
            w_hold_cnt_nxt  = '0;
            w_rst_n_out_nxt = 1'b1;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt + HC_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (sw_rst) begin
          w_state_nxt     = ST_HOLD;
          w_hold_cnt_nxt  = '0;
          w_rst_n_out_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt     = ST_HOLD;
        w_hold_cnt_nxt  = '0;
        w_rst_n_out_nxt = 1'b0;
      end
    endcase
  end

  assign w_div_m1  = r_div_reg - DIV_W'(1);
  assign w_wrap    = (r_cnt == w_div_m1);
  assign w_div_wr  = (div_val == '0) ? DIV_W'(1) : div_val;
  assign w_div_clr = (r_state == ST_HOLD) || sw_rst;

  // sw_rst outranks a divider write, so the register is only loaded without it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_reg    <= DIV_RST_VAL;
      r_cnt        <= '0;
      r_tick       <= 1'b0;
      r_ck_div     <= 1'b0;
      r_tick_count <= '0;
    end else begin
      if (div_we && !sw_rst) begin
        r_div_reg <= w_div_wr;
      end
      if (w_div_clr) begin
        r_cnt        <= '0;
        r_tick       <= 1'b0;
        r_ck_div     <= 1'b0;
        r_tick_count <= '0;
      end else if (div_we) begin
        r_cnt  <= '0;
        r_tick <= 1'b0;
      end else if (tick_en) begin
        if (w_wrap) begin
          r_cnt        <= '0;
          r_tick       <= 1'b1;
          r_ck_div     <= ~r_ck_div;
          r_tick_count <= r_tick_count + TCNT_W'(1);
        end else begin
          r_cnt  <= r_cnt + DIV_W'(1);
          r_tick <= 1'b0;
        end
      end else begin
        r_tick <= 1'b0;
      end
    end
  end

  assign rst_n_out  = r_rst_n_out;
  assign tick       = r_tick;
  assign ck_div     = r_ck_div;
  assign tick_count = r_tick_count;

endmodule
